// File: rtl/btb_update_scheduler.sv
// Two-requester branch-target update queue: merges A/B updates into a small FIFO,
// suppresses duplicate source pcs and issues one packed update per unstalled cycle.
module btb_update_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IN_updA_valid,
    input  logic [30:0]              IN_updA_src,
    input  logic [30:0]              IN_updA_dst,
    input  logic                     IN_updA_isJump,
    input  logic                     IN_updA_compr,
    input  logic                     IN_updB_valid,
    input  logic [30:0]              IN_updB_src,
    input  logic [30:0]              IN_updB_dst,
    input  logic                     IN_updB_isJump,
    input  logic                     IN_updB_compr,
    output logic                     OUT_updA_ready,
    output logic                     OUT_updB_ready,
    input  logic                     IN_stall,
    input  logic                     IN_flush,
    output logic [66:0]              OUT_btUpdate,
    output logic [$clog2(DEPTH):0]   OUT_count,
    output logic [7:0]               OUT_dropCnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshake: a request transfers in any cycle where its valid and ready are both
    // high; ready is a function of registered occupancy and the current valids only,
    // so a pop in the same cycle never opens a slot for a new request.

    logic [30:0]      src_q [DEPTH];
    logic [30:0]      dst_q [DEPTH];
    logic [DEPTH-1:0] jmp_q;
    logic [DEPTH-1:0] cmp_q;

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    b_slot;
    logic             rr_b;

    logic [CW-1:0]    free;
    logic             contested;
    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] hit_a_vec;
    logic [DEPTH-1:0] hit_b_vec;
    logic             hit_a;
    logic             hit_b;
    logic             xfer_a;
    logic             xfer_b;
    logic             dup_a;
    logic             dup_b;
    logic             push_a;
    logic             push_b;
    logic             pop;
    logic [66:0]      head_word;
    logic [8:0]       drop_sum;
    logic [7:0]       drop_next;

    assign free = DEPTH_C - OUT_count;

    always_comb begin
        OUT_updA_ready = 1'b0;
        OUT_updB_ready = 1'b0;
        contested      = 1'b0;
        if (!IN_flush) begin
            if (free >= CW'(2)) begin
                OUT_updA_ready = 1'b1;
                OUT_updB_ready = 1'b1;
            end else if (free == CW'(1)) begin
                if (IN_updA_valid && IN_updB_valid) begin
                    // Single slot, both asking: the round-robin pointer decides.
                    contested      = 1'b1;
                    OUT_updA_ready = !rr_b;
                    OUT_updB_ready = rr_b;
                end else begin
                    OUT_updA_ready = IN_updA_valid;
                    OUT_updB_ready = IN_updB_valid;
                end
            end
        end
    end

    // A slot is occupied when its distance from the read pointer is below occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_occ
        logic [PW-1:0] offset;
        assign offset       = PW'(i) - rd_ptr;
        assign occ[i]       = {1'b0, offset} < OUT_count;
        assign hit_a_vec[i] = occ[i] && (src_q[i] == IN_updA_src);
        assign hit_b_vec[i] = occ[i] && (src_q[i] == IN_updB_src);
    end

    assign hit_a  = |hit_a_vec;
    assign hit_b  = |hit_b_vec;

    assign xfer_a = IN_updA_valid && OUT_updA_ready;
    assign xfer_b = IN_updB_valid && OUT_updB_ready;
    assign dup_a  = xfer_a && hit_a;
    assign dup_b  = xfer_b && (hit_b || (xfer_a && (IN_updA_src == IN_updB_src)));
    assign push_a = xfer_a && !dup_a;
    assign push_b = xfer_b && !dup_b;
    assign pop    = !IN_flush && !IN_stall && (OUT_count != '0);

    // B lands behind A when both are written in the same cycle.
    assign b_slot = wr_ptr + PW'(push_a);

    assign head_word = {src_q[rd_ptr], 1'b0, dst_q[rd_ptr], 1'b0,
                        jmp_q[rd_ptr], cmp_q[rd_ptr], 1'b1};

    assign drop_sum  = {1'b0, OUT_dropCnt} + 9'(dup_a) + 9'(dup_b);
    assign drop_next = drop_sum[8] ? 8'hff : drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (push_a) begin
            src_q[wr_ptr] <= IN_updA_src;
            dst_q[wr_ptr] <= IN_updA_dst;
            jmp_q[wr_ptr] <= IN_updA_isJump;
            cmp_q[wr_ptr] <= IN_updA_compr;
        end
        if (push_b) begin
            src_q[b_slot] <= IN_updB_src;
            dst_q[b_slot] <= IN_updB_dst;
            jmp_q[b_slot] <= IN_updB_isJump;
            cmp_q[b_slot] <= IN_updB_compr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            OUT_count    <= '0;
            rr_b         <= 1'b0;
            OUT_btUpdate <= '0;
            OUT_dropCnt  <= '0;
        end else if (IN_flush) begin
            // Drop count and arbitration history survive a flush.
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            OUT_count    <= '0;
            OUT_btUpdate <= '0;
        end else begin
            wr_ptr       <= wr_ptr + PW'(push_a) + PW'(push_b);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            OUT_count    <= OUT_count + CW'(push_a) + CW'(push_b) - CW'(pop);
            OUT_btUpdate <= pop ? head_word : '0;
            if (contested) begin
                rr_b <= !rr_b;
            end
            OUT_dropCnt  <= drop_next;
        end
    end

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Directed bench for btb_update_scheduler: queue-based reference model compared every
// cycle, plus literal expectations for the key scenarios.
module tb_btb_update_scheduler;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        IN_updA_valid;
    logic [30:0] IN_updA_src;
    logic [30:0] IN_updA_dst;
    logic        IN_updA_isJump;
    logic        IN_updA_compr;
    logic        IN_updB_valid;
    logic [30:0] IN_updB_src;
    logic [30:0] IN_updB_dst;
    logic        IN_updB_isJump;
    logic        IN_updB_compr;
    logic        OUT_updA_ready;
    logic        OUT_updB_ready;
    logic        IN_stall;
    logic        IN_flush;
    logic [66:0] OUT_btUpdate;
    logic [$clog2(DEPTH):0] OUT_count;
    logic [7:0]  OUT_dropCnt;

    btb_update_scheduler #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .IN_updA_valid (IN_updA_valid),
        .IN_updA_src   (IN_updA_src),
        .IN_updA_dst   (IN_updA_dst),
        .IN_updA_isJump(IN_updA_isJump),
        .IN_updA_compr (IN_updA_compr),
        .IN_updB_valid (IN_updB_valid),
        .IN_updB_src   (IN_updB_src),
        .IN_updB_dst   (IN_updB_dst),
        .IN_updB_isJump(IN_updB_isJump),
        .IN_updB_compr (IN_updB_compr),
        .OUT_updA_ready(OUT_updA_ready),
        .OUT_updB_ready(OUT_updB_ready),
        .IN_stall      (IN_stall),
        .IN_flush      (IN_flush),
        .OUT_btUpdate  (OUT_btUpdate),
        .OUT_count     (OUT_count),
        .OUT_dropCnt   (OUT_dropCnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    typedef struct packed {
        logic [30:0] src;
        logic [30:0] dst;
        logic        jmp;
        logic        cmp;
    } ent_t;

    ent_t        mq[$];
    logic        m_rr = 1'b0;
    int          m_drop = 0;
    logic [66:0] m_bt = '0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [1:0] model_ready(int n, logic rr, logic va, logic vb, logic fl);
        int f = DEPTH - n;
        if (fl || f == 0) return 2'b00;
        if (f >= 2) return 2'b11;
        if (va && vb) return rr ? 2'b01 : 2'b10;
        return {va, vb};
    endfunction

    function automatic logic in_queue(logic [30:0] s);
        foreach (mq[i]) if (mq[i].src == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [66:0] pack(ent_t e);
        return {e.src, 1'b0, e.dst, 1'b0, e.jmp, e.cmp, 1'b1};
    endfunction

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each active edge (or reset assertion).
    initial forever begin
        logic [1:0] r;
        logic xa, xb, da, db;
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_rr   = 1'b0;
            m_drop = 0;
            m_bt   = '0;
        end else if (IN_flush) begin
            mq.delete();
            m_bt = '0;
        end else begin
            r  = model_ready(mq.size(), m_rr, IN_updA_valid, IN_updB_valid, 1'b0);
            xa = IN_updA_valid && r[1];
            xb = IN_updB_valid && r[0];
            da = xa && in_queue(IN_updA_src);
            db = xb && (in_queue(IN_updB_src) || (xa && IN_updA_src == IN_updB_src));
            if (IN_updA_valid && IN_updB_valid && (DEPTH - mq.size()) == 1) m_rr = !m_rr;
            if (!IN_stall && mq.size() > 0) begin
                m_bt = pack(mq[0]);
                void'(mq.pop_front());
            end else begin
                m_bt = '0;
            end
            if (xa && !da) mq.push_back('{IN_updA_src, IN_updA_dst, IN_updA_isJump, IN_updA_compr});
            if (xb && !db) mq.push_back('{IN_updB_src, IN_updB_dst, IN_updB_isJump, IN_updB_compr});
            m_drop = m_drop + int'(da) + int'(db);
            if (m_drop > 255) m_drop = 255;
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        logic [1:0] er;
        @(negedge clk);
        er = model_ready(mq.size(), m_rr, IN_updA_valid, IN_updB_valid, IN_flush);
        check("bt_update", OUT_btUpdate, m_bt);
        check("count", 67'(OUT_count), 67'(mq.size()));
        check("drop_cnt", 67'(OUT_dropCnt), 67'(m_drop));
        check("ready_a", 67'(OUT_updA_ready), 67'(er[1]));
        check("ready_b", 67'(OUT_updB_ready), 67'(er[0]));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [30:0] s, input logic [30:0] d, input logic j, input logic c);
        IN_updA_valid  = 1'b1;
        IN_updA_src    = s;
        IN_updA_dst    = d;
        IN_updA_isJump = j;
        IN_updA_compr  = c;
    endtask

    task automatic set_b(input logic [30:0] s, input logic [30:0] d, input logic j, input logic c);
        IN_updB_valid  = 1'b1;
        IN_updB_src    = s;
        IN_updB_dst    = d;
        IN_updB_isJump = j;
        IN_updB_compr  = c;
    endtask

    task automatic idle();
        IN_updA_valid = 1'b0;
        IN_updB_valid = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b0;
        IN_updA_valid = 1'b0; IN_updA_src = '0; IN_updA_dst = '0;
        IN_updA_isJump = 1'b0; IN_updA_compr = 1'b0;
        IN_updB_valid = 1'b0; IN_updB_src = '0; IN_updB_dst = '0;
        IN_updB_isJump = 1'b0; IN_updB_compr = 1'b0;
        IN_stall = 1'b0;
        IN_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_count", 67'(OUT_count), 67'(0));
        check("reset_bt", OUT_btUpdate, 67'(0));

        // Single update into an empty queue: visible two cycles later, for one cycle.
        tick();
        set_a(31'h100, 31'h200, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        @(negedge clk);
        check("lat2_word", OUT_btUpdate, 67'h100000002005);
        tick();
        @(negedge clk);
        check("lat2_clear", OUT_btUpdate, 67'(0));

        // One free slot contested twice: A first, then B.
        tick();
        IN_stall = 1'b1;
        set_a(31'h10, 31'h110, 1'b0, 1'b1);
        set_b(31'h14, 31'h114, 1'b1, 1'b0);
        tick();
        IN_updB_valid = 1'b0;
        set_a(31'h18, 31'h118, 1'b1, 1'b1);
        tick();
        set_a(31'h20, 31'h120, 1'b0, 1'b0);
        set_b(31'h24, 31'h124, 1'b1, 1'b1);
        @(negedge clk);
        check("rr_first_a", 67'({OUT_updA_ready, OUT_updB_ready}), 67'(2'b10));
        tick();
        @(negedge clk);
        check("rr_full_count", 67'(OUT_count), 67'(DEPTH));
        check("rr_full_ready", 67'({OUT_updA_ready, OUT_updB_ready}), 67'(2'b00));
        tick();
        IN_stall = 1'b0;
        idle();
        tick();
        IN_stall = 1'b1;
        set_a(31'h28, 31'h128, 1'b0, 1'b0);
        set_b(31'h24, 31'h124, 1'b1, 1'b1);
        @(negedge clk);
        check("rr_second_b", 67'({OUT_updA_ready, OUT_updB_ready}), 67'(2'b01));
        tick();
        @(negedge clk);
        check("rr_full_again", 67'(OUT_count), 67'(DEPTH));
        tick();
        IN_stall = 1'b0;
        idle();
        repeat (6) tick();

        // Duplicate suppression: same-cycle pair, then a repeat of a queued src.
        IN_stall = 1'b1;
        set_a(31'h40, 31'h400, 1'b0, 1'b0);
        set_b(31'h40, 31'h440, 1'b1, 1'b0);
        tick();
        idle();
        @(negedge clk);
        check("dup_pair_count", 67'(OUT_count), 67'(1));
        check("dup_pair_drop", 67'(OUT_dropCnt), 67'(1));
        set_a(31'h40, 31'h480, 1'b1, 1'b1);
        tick();
        idle();
        @(negedge clk);
        check("dup_repeat_drop", 67'(OUT_dropCnt), 67'(2));
        check("dup_repeat_count", 67'(OUT_count), 67'(1));
        IN_stall = 1'b0;
        repeat (3) tick();

        // Fill, stall three cycles, then drain in enqueue order.
        IN_stall = 1'b1;
        set_a(31'h50, 31'h150, 1'b0, 1'b1);
        set_b(31'h54, 31'h154, 1'b1, 1'b0);
        tick();
        set_a(31'h58, 31'h158, 1'b1, 1'b1);
        set_b(31'h5c, 31'h15c, 1'b0, 1'b0);
        tick();
        set_a(31'h60, 31'h160, 1'b0, 1'b0);
        set_b(31'h64, 31'h164, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_bt", OUT_btUpdate, 67'(0));
            check("stall_ready", 67'({OUT_updA_ready, OUT_updB_ready}), 67'(2'b00));
            tick();
        end
        idle();
        IN_stall = 1'b0;
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            check("drain_valid", 67'(OUT_btUpdate[0]), 67'(1));
            check("drain_order", 67'(OUT_btUpdate[66:36]), 67'(31'h50 + 31'(4 * k)));
            tick();
        end

        // Flush with three entries queued and both requesters asking.
        IN_stall = 1'b1;
        set_a(31'h70, 31'h170, 1'b1, 1'b0);
        set_b(31'h74, 31'h174, 1'b0, 1'b1);
        tick();
        IN_updB_valid = 1'b0;
        set_a(31'h78, 31'h178, 1'b0, 1'b0);
        tick();
        set_a(31'h7c, 31'h17c, 1'b0, 1'b0);
        set_b(31'h80, 31'h180, 1'b0, 1'b0);
        IN_flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 67'({OUT_updA_ready, OUT_updB_ready}), 67'(2'b00));
        tick();
        IN_flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_count", 67'(OUT_count), 67'(0));
        check("flush_bt", OUT_btUpdate, 67'(0));
        IN_stall = 1'b0;
        tick();

        // Mixed traffic from a small src pool so duplicates and contention recur.
        for (int k = 0; k < 60; k++) begin
            IN_updA_valid  = 1'($urandom_range(0, 1));
            IN_updA_src    = 31'h90 + 31'(4 * $urandom_range(0, 3));
            IN_updA_dst    = 31'($urandom_range(0, 32'h7fff));
            IN_updA_isJump = 1'($urandom_range(0, 1));
            IN_updA_compr  = 1'($urandom_range(0, 1));
            IN_updB_valid  = 1'($urandom_range(0, 1));
            IN_updB_src    = 31'h90 + 31'(4 * $urandom_range(0, 3));
            IN_updB_dst    = 31'($urandom_range(0, 32'h7fff));
            IN_updB_isJump = 1'($urandom_range(0, 1));
            IN_updB_compr  = 1'($urandom_range(0, 1));
            IN_stall       = ($urandom_range(0, 2) == 0);
            IN_flush       = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle();
        IN_stall = 1'b0;
        IN_flush = 1'b0;
        repeat (6) tick();

        // Drop counter saturation: two duplicates per cycle against a held entry.
        IN_stall = 1'b1;
        set_a(31'h77, 31'h177, 1'b0, 1'b0);
        tick();
        set_b(31'h77, 31'h1f7, 1'b1, 1'b1);
        repeat (130) tick();
        idle();
        @(negedge clk);
        check("drop_saturate", 67'(OUT_dropCnt), 67'(255));
        IN_stall = 1'b0;
        repeat (3) tick();

        // Asynchronous reset while draining.
        IN_stall = 1'b1;
        set_a(31'ha0, 31'h1a0, 1'b1, 1'b0);
        set_b(31'ha4, 31'h1a4, 1'b0, 1'b1);
        tick();
        IN_updB_valid = 1'b0;
        set_a(31'ha8, 31'h1a8, 1'b1, 1'b1);
        tick();
        idle();
        IN_stall = 1'b0;
        tick();
        @(negedge clk);
        check("rst_pre_valid", 67'(OUT_btUpdate[0]), 67'(1));
        #2 rst = 1'b0;
        #1;
        check("rst_async_bt", OUT_btUpdate, 67'(0));
        check("rst_async_count", 67'(OUT_count), 67'(0));
        check("rst_async_drop", 67'(OUT_dropCnt), 67'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_no_residual", OUT_btUpdate, 67'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
